// File: rtl/instr_responder_pkg.sv
// Shared types and default widths for the instruction responder slice.
package instr_pkg;

    localparam int DATA_W = 16;
    localparam int OUT_W  = 32;

    typedef enum logic [1:0] {
        INSTR_WRITE = 2'b00,
        INSTR_READ  = 2'b01,
        INSTR_ADD   = 2'b10,
        INSTR_MUL   = 2'b11
    } instr_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/instr_responder_if.sv
// Single-beat request / result bus between an instruction master and the responder.
interface instr_responder_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int OUT_W    = 32
);

    localparam int SEL_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] data_i;
    logic [SEL_W-1:0]  reg_sel;
    logic [1:0]        instru;
    logic              valid_i;
    logic [OUT_W-1:0]  data_o;
    logic              valid_o;
    logic              busy_o;

    modport master (
        output data_i, reg_sel, instru, valid_i,
        input  data_o, valid_o, busy_o
    );

    modport slave (
        input  data_i, reg_sel, instru, valid_i,
        output data_o, valid_o, busy_o
    );

endinterface

// File: rtl/instr_responder_shift_add_mult.sv
// Iterative shift-add multiplier: one partial product per step, DATA_W steps per product.
module shift_add_mult #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [OUT_W-1:0]  a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              done,
    output logic [OUT_W-1:0]  product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [OUT_W-1:0]  a;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic [DATA_W-1:0] b;
    logic [CNT_W-1:0]  cnt;

    assign acc_next = b[0] ? acc + a : acc;

    // The last step's partial product is folded in combinationally, so the
    // caller can register the exact product on the same edge done is seen.
    assign done    = step && (cnt == CNT_W'(DATA_W - 1));
    assign product = acc_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a   <= '0;
            b   <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            a   <= a_in;
            b   <= b_in;
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc_next;
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_responder.sv
// Responder for single-beat WRITE/READ/ADD/MUL requests over a small register file.
// Define INSTR_RESPONDER_DROP_CNT_EN to add drop_cnt_o, a saturating count of dropped requests.
module instr_responder #(
    parameter int DATA_W   = instr_pkg::DATA_W,
    parameter int NUM_REGS = 4,
    parameter int OUT_W    = instr_pkg::OUT_W
) (
    input  logic               clk,
    input  logic               rst,
    instr_responder_if.slave   bus
`ifdef INSTR_RESPONDER_DROP_CNT_EN
    ,
    output logic [7:0]         drop_cnt_o
`endif
);

    instr_pkg::state_e state;
    instr_pkg::state_e next_state;
    instr_pkg::instr_e op;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] sel_val;
    logic [DATA_W:0]   sum;

    logic              accept;
    logic              mult_start;
    logic              mult_step;
    logic              mult_done;
    logic [OUT_W-1:0]  product;

    assign op      = instr_pkg::instr_e'(bus.instru);
    assign sel_val = regs[bus.reg_sel];
    assign sum     = {1'b0, sel_val} + {1'b0, bus.data_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= instr_pkg::ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        next_state = state;
        unique case (state)
            instr_pkg::ST_IDLE: if (mult_start) next_state = instr_pkg::ST_MUL;
            instr_pkg::ST_MUL:  if (mult_done)  next_state = instr_pkg::ST_IDLE;
            default:            next_state = instr_pkg::ST_IDLE;
        endcase
    end

    // Requests arriving while a multiply is iterating are never accepted.
    always_comb begin
        accept     = 1'b0;
        mult_start = 1'b0;
        mult_step  = 1'b0;
        unique case (state)
            instr_pkg::ST_IDLE: begin
                accept     = bus.valid_i;
                mult_start = bus.valid_i && (op == instr_pkg::INSTR_MUL);
            end
            instr_pkg::ST_MUL: begin
                mult_step  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy_o = (state == instr_pkg::ST_MUL);

    shift_add_mult #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mult_start),
        .step    (mult_step),
        .a_in    (OUT_W'(sel_val)),
        .b_in    (bus.data_i),
        .done    (mult_done),
        .product (product)
    );

    // NOTE: the register file is reset explicitly because a READ straight
    // after reset must return zero, so it cannot map onto reset-less RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            bus.data_o  <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= 1'b0;
            if (accept) begin
                unique case (op)
                    instr_pkg::INSTR_WRITE: regs[bus.reg_sel] <= bus.data_i;
                    instr_pkg::INSTR_READ: begin
                        bus.data_o  <= OUT_W'(sel_val);
                        bus.valid_o <= 1'b1;
                    end
                    instr_pkg::INSTR_ADD: begin
                        bus.data_o  <= OUT_W'(sum);
                        bus.valid_o <= 1'b1;
                    end
                    instr_pkg::INSTR_MUL: ;
                    default: ;
                endcase
            end else if (mult_done) begin
                bus.data_o  <= product;
                bus.valid_o <= 1'b1;
            end
        end
    end

`ifdef INSTR_RESPONDER_DROP_CNT_EN
    logic drop;

    assign drop = (state == instr_pkg::ST_MUL) && bus.valid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_o <= '0;
        end else if (drop && (drop_cnt_o != 8'hFF)) begin
            drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_responder.sv
// Self-checking bench for instr_responder: directed cases plus randomized traffic vs. a behavioural model.
module tb_instr_responder;
    import instr_pkg::*;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_responder_if #(.DATA_W(DATA_W), .NUM_REGS(NR), .OUT_W(OUT_W)) bus ();

`ifdef INSTR_RESPONDER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    instr_responder #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NR),
        .OUT_W    (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef INSTR_RESPONDER_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a multiply is simply a product due DATA_W edges after acceptance.
    logic [15:0] m_regs [NR];
    logic [31:0] exp_data  = '0;
    logic        exp_valid = 1'b0;
    int          mul_left  = 0;
    logic [31:0] mul_prod  = '0;
    int          m_drop    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] <= '0;
            exp_data  <= '0;
            exp_valid <= 1'b0;
            mul_left  <= 0;
            m_drop    <= 0;
        end else begin
            exp_valid <= 1'b0;
            if (mul_left > 0) begin
                if (bus.valid_i && m_drop < 255) m_drop <= m_drop + 1;
                mul_left <= mul_left - 1;
                if (mul_left == 1) begin
                    exp_data  <= mul_prod;
                    exp_valid <= 1'b1;
                end
            end else if (bus.valid_i) begin
                case (bus.instru)
                    2'b00: m_regs[bus.reg_sel] <= bus.data_i;
                    2'b01: begin
                        exp_data  <= 32'(m_regs[bus.reg_sel]);
                        exp_valid <= 1'b1;
                    end
                    2'b10: begin
                        exp_data  <= 32'(m_regs[bus.reg_sel]) + 32'(bus.data_i);
                        exp_valid <= 1'b1;
                    end
                    default: begin
                        mul_prod <= 32'(m_regs[bus.reg_sel]) * 32'(bus.data_i);
                        mul_left <= DATA_W;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("data_o", bus.data_o, exp_data);
        check("valid_o", 32'(bus.valid_o), 32'(exp_valid));
        check("busy_o", 32'(bus.busy_o), 32'(mul_left != 0));
`ifdef INSTR_RESPONDER_DROP_CNT_EN
        check("drop_cnt_o", 32'(drop_cnt), 32'(m_drop));
`endif
    end

    task automatic req(input logic [1:0] op, input logic [1:0] sel, input logic [15:0] d);
        bus.instru  = op;
        bus.reg_sel = sel;
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy_cycles);
        lat         = 1;
        busy_cycles = 0;
        forever begin
            if (bus.busy_o) busy_cycles++;
            if (bus.valid_o || lat >= 40) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int busy_cycles;

        bus.valid_i = 1'b0;
        bus.instru  = 2'b00;
        bus.reg_sel = '0;
        bus.data_i  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data_o", bus.data_o, 32'h0);
        check("reset_valid_o", 32'(bus.valid_o), 32'h0);
        check("reset_busy_o", 32'(bus.busy_o), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // WRITE then READ returns the new value one cycle after the READ accept.
        req(2'b00, 2'd2, 16'h1234);
        req(2'b01, 2'd2, 16'h0000);
        check("read_reg2_valid", 32'(bus.valid_o), 32'h1);
        check("read_reg2_data", bus.data_o, 32'h0000_1234);
        @(posedge clk);
        #1;
        check("read_reg2_pulse_end", 32'(bus.valid_o), 32'h0);

        // ADD carries into bit DATA_W and leaves the register untouched.
        req(2'b00, 2'd1, 16'hFFFF);
        req(2'b10, 2'd1, 16'h0001);
        check("add_carry_valid", 32'(bus.valid_o), 32'h1);
        check("add_carry_data", bus.data_o, 32'h0001_0000);
        req(2'b01, 2'd1, 16'h0000);
        check("add_reg_unchanged", bus.data_o, 32'h0000_FFFF);

        // Largest product, latency and busy length.
        req(2'b00, 2'd3, 16'hFFFF);
        req(2'b11, 2'd3, 16'hFFFF);
        wait_result(lat, busy_cycles);
        check("mul_latency", 32'(lat), 32'd17);
        check("mul_busy_cycles", 32'(busy_cycles), 32'd16);
        check("mul_max_data", bus.data_o, 32'hFFFE_0001);

        // Writes arriving during a multiply (including its final edge) are dropped.
        req(2'b11, 2'd3, 16'h0002);
        for (int k = 1; k <= 16; k++) begin
            bus.instru  = 2'b00;
            bus.reg_sel = 2'd0;
            bus.data_i  = 16'hAAAA;
            bus.valid_i = (k == 5 || k == 16);
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        check("mul_drop_valid", 32'(bus.valid_o), 32'h1);
        check("mul_drop_data", bus.data_o, 32'h0001_FFFE);
        req(2'b01, 2'd0, 16'h0000);
        check("drop_reg0_unwritten", bus.data_o, 32'h0);
`ifdef INSTR_RESPONDER_DROP_CNT_EN
        check("drop_cnt_two", 32'(drop_cnt), 32'd2);
`endif

        // Reset in the middle of a multiply aborts it.
        req(2'b00, 2'd1, 16'h0003);
        req(2'b11, 2'd1, 16'h0005);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_data_o", bus.data_o, 32'h0);
        check("abort_busy_o", 32'(bus.busy_o), 32'h0);
        check("abort_valid_o", 32'(bus.valid_o), 32'h0);
        rst = 1'b0;
        for (int r = 0; r < NR; r++) begin
            req(2'b01, 2'(r), 16'h0000);
            check("post_reset_read_valid", 32'(bus.valid_o), 32'h1);
            check("post_reset_read_data", bus.data_o, 32'h0);
        end
        repeat (20) @(posedge clk);
        #1;

        // Back-to-back READ / ADD / READ.
        req(2'b00, 2'd0, 16'h0010);
        req(2'b01, 2'd0, 16'h0000);
        check("b2b_read1", bus.data_o, 32'h0000_0010);
        check("b2b_read1_valid", 32'(bus.valid_o), 32'h1);
        req(2'b10, 2'd0, 16'h0007);
        check("b2b_add", bus.data_o, 32'h0000_0017);
        check("b2b_add_valid", 32'(bus.valid_o), 32'h1);
        req(2'b01, 2'd0, 16'h0000);
        check("b2b_read2", bus.data_o, 32'h0000_0010);
        check("b2b_read2_valid", 32'(bus.valid_o), 32'h1);

        // Randomized traffic, including requests during multiplies and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                bus.valid_i = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                bus.valid_i = ($urandom_range(0, 9) < 7);
                bus.instru  = 2'($urandom_range(0, 3));
                bus.reg_sel = 2'($urandom_range(0, NR - 1));
                bus.data_i  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                @(posedge clk);
                #1;
            end
        end
        bus.valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_responder.md
Name: instr_responder

Overview:
Responder end of the instruction/data interface. It accepts single-beat requests (data_i, reg_sel, instru, valid_i), operates on a small internal register file, and returns 32-bit results on data_o with a one-cycle valid_o pulse. Read and add complete in one cycle. Multiply is iterative shift-add, and the block reports busy while a multiply is in progress. It is the DUT that the bench master drives through the clocking block.

Parameters:
DATA_W, 16, request data width and register width
NUM_REGS, 4, register file depth; reg_sel width is $clog2(NUM_REGS)
OUT_W, 32, result width; must equal 2*DATA_W

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
data_i  input  DATA_W  request operand
reg_sel  input  2  register index
instru  input  2  opcode: 00 WRITE, 01 READ, 10 ADD, 11 MUL
valid_i  input  1  request strobe; single beat, no ready
data_o  output  OUT_W  result; holds its last value between results
valid_o  output  1  one-cycle result strobe
busy_o  output  1  high while a MUL is in progress; requests are dropped

Behaviour:
- Reset: regs[*]=0, data_o=0, valid_o=0, busy_o=0, state=IDLE, iteration counter=0. Reset asserted mid-MUL aborts the multiply; no valid_o is produced.
- A request is accepted when valid_i=1 and state=IDLE at a posedge. Any valid_i sampled while state=MUL is dropped silently: no register change, no output.
- WRITE: regs[reg_sel] <= data_i. No valid_o.
- READ: data_o <= zero-extended regs[reg_sel]. valid_o=1 in the next cycle (latency 1).
- ADD: data_o <= zero-extended (regs[reg_sel] + data_i), computed as a (DATA_W+1)-bit sum, so the carry appears in bit DATA_W. valid_o=1 in the next cycle. The register file is not modified.
- MUL, operand capture at accept edge T0:
  - A = zero-extended regs[reg_sel] (OUT_W bits)
  - B = data_i
  - acc = 0, cnt = 0
  - state -> MUL; busy_o=1 from the cycle after T0.
- MUL iterations at edges T1..T_DATA_W:
  - if B[0], acc += A
  - A <<= 1, B >>= 1, cnt++
- MUL completion at edge T_DATA_W:
  - data_o <= final acc, valid_o=1, state -> IDLE, busy_o -> 0
  - Result appears DATA_W+1 cycles after acceptance (17 for the defaults).
  - valid_i sampled at T_DATA_W is still dropped.
  - A new request is accepted from T_DATA_W+1 onward.
- MUL does not write the register file. The product is exact; 0xFFFF*0xFFFF fits in 32 bits.
- valid_o is high for exactly one cycle per READ/ADD/MUL result and is 0 in every other cycle.
- Back-to-back READ/ADD requests on consecutive cycles give consecutive valid_o pulses.
- WRITE followed by READ of the same register on the next cycle returns the new value.
- States: IDLE (accepts requests) and MUL (iterating). IDLE -> MUL on an accepted MUL; MUL -> IDLE when cnt reaches DATA_W-1 at an iteration edge.

Optional Feature:
INSTR_RESPONDER_DROP_CNT_EN
- Defined: adds output port drop_cnt_o[7:0]. It increments on each valid_i sampled while state=MUL, saturates at 255, and is cleared by rst.
- Undefined: the port and counter are absent, and drops are not recorded.

Decomposition:
- Package instr_pkg holds:
  - typedef enum logic [1:0] instr_e {INSTR_WRITE, INSTR_READ, INSTR_ADD, INSTR_MUL}
  - typedef enum logic state_e {ST_IDLE, ST_MUL}
  - localparams DATA_W=16 and OUT_W=32
- One sub-module, shift_add_mult, contains the A/B/acc/cnt datapath with start and done pulses. The top-level module owns the register file, the opcode decode and the output registers.

Test Plan:
- WRITE reg2=0x1234, then READ reg2 -> data_o=0x00001234, valid_o high for 1 cycle, one cycle after the READ accept.
- WRITE reg1=0xFFFF, ADD reg1 with data_i=0x0001 -> data_o=0x00010000 with latency 1; a subsequent READ reg1 still returns 0x0000FFFF.
- WRITE reg3=0xFFFF, MUL reg3 with data_i=0xFFFF -> data_o=0xFFFE0001, valid_o exactly 17 cycles after accept; busy_o high for 16 cycles.
- During a MUL, drive WRITE reg0=0xAAAA at cycles 5 and 16 after accept -> both dropped; READ reg0 afterwards returns 0. With INSTR_RESPONDER_DROP_CNT_EN defined, drop_cnt_o=2.
- Start MUL 3*5, assert rst at cycle 8 -> no valid_o, data_o=0, busy_o=0, all registers 0. A READ immediately after reset is served normally.
- Back-to-back READ reg0, ADD reg0 with 7, READ reg0 on 3 consecutive cycles (reg0=0x10) -> 3 consecutive valid_o pulses carrying 0x10, 0x17, 0x10.
